phase_scheduler: RTL

Round-robin scheduler that shares a single `phasecalc` (CORDIC rectangular-to-polar) engine among `NCH` independent Hilbert-filter channels. Each channel posts I/Q pairs into a one-deep pending slot. The scheduler dispatches pending pairs to the engine one at a time using its `start`/`busy` handshake, and returns each angle tagged with its channel number. It sits between the per-channel Hilbert filters and the downstream phase-difference/unwrap logic.

---
 rtl/phase_scheduler_pkg.sv | 6 +
 rtl/phase_scheduler_rr_arbiter.sv | 26 ++
 rtl/phase_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/phase_scheduler_pkg.sv
// phase_scheduler_pkg: shared FSM encoding and 9.10-format angle constants
package phase_scheduler_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_DONE} state_t;
    localparam int ANGLE_180 = 184320;
    localparam int ANGLE_90 = 92160;
endpackage

// File: rtl/phase_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] pend,
    input  logic [CHW-1:0] last,
    output logic [CHW-1:0] grant,
    output logic           any
);
    // walk offsets from farthest to nearest so the nearest pending channel wins
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        any = 1'b0;
        for (int i = NCH; i >= 1; i--) begin
            j = int'(last) + i;
            j = (j >= NCH) ? j - NCH : j;
            if (pend[j[CHW-1:0]]) begin
                grant = j[CHW-1:0];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: round-robin sharing of one phasecalc engine among NCH channels
module phase_scheduler #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int INSIZE = 13,
    parameter int OUTSIZE = 19
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*INSIZE-1:0] in_x,
    input  logic [NCH*INSIZE-1:0] in_y,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_chan,
    output logic [OUTSIZE-1:0]    out_angle,
    output logic [NCH-1:0]        overrun,
    output logic                  pc_start,
    output logic [INSIZE-1:0]     pc_x,
    output logic [INSIZE-1:0]     pc_y,
    input  logic                  pc_busy,
    input  logic [OUTSIZE-1:0]    pc_angle
);
    import phase_scheduler_pkg::*;

    state_t state, state_n;
    logic [NCH-1:0] pend, disp;
    logic [INSIZE-1:0] slot_x [NCH];
    logic [INSIZE-1:0] slot_y [NCH];
    logic [CHW-1:0] last_grant, grant, cur_chan;
    logic any, take;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .pend(pend),
        .last(last_grant),
        .grant(grant),
        .any(any)
    );

    assign take = any && (state == S_IDLE || state == S_DONE);
    assign disp = take ? NCH'(1) << grant : '0;
    assign pc_start = state == S_START;
    assign out_valid = state == S_DONE;

    // pending slots: newest sample wins; overrun only when the old one was never dispatched
    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= '0;
            overrun <= '0;
            for (int k = 0; k < NCH; k++) begin
                slot_x[k] <= '0;
                slot_y[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (in_valid[k]) begin
                    slot_x[k] <= in_x[k*INSIZE +: INSIZE];
                    slot_y[k] <= in_y[k*INSIZE +: INSIZE];
                    pend[k] <= 1'b1;
                    if (pend[k] && !disp[k]) overrun[k] <= 1'b1;
                end else if (disp[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    // state register
    always_ff @(posedge clock) begin
        state <= reset ? S_IDLE : state_n;
    end

    // next state: ARM skips one cycle so the engine's registered busy is seen in WAIT
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = any ? S_START : S_IDLE;
            S_START: state_n = S_ARM;
            S_ARM:   state_n = S_WAIT;
            S_WAIT:  state_n = pc_busy ? S_WAIT : S_DONE;
            S_DONE:  state_n = any ? S_START : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // grant capture into engine operands and result capture when busy falls
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= CHW'(NCH-1);
            cur_chan <= '0;
            pc_x <= '0;
            pc_y <= '0;
            out_chan <= '0;
            out_angle <= '0;
        end else begin
            if (take) begin
                last_grant <= grant;
                cur_chan <= grant;
                pc_x <= slot_x[grant];
                pc_y <= slot_y[grant];
            end
            if (state == S_WAIT && !pc_busy) begin
                out_angle <= pc_angle;
                out_chan <= cur_chan;
            end
        end
    end
endmodule
